// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency word memory serving fetch, load and store channels
// Defining MEM_BYTE_STROBE_EN adds store_strb for per-byte store lane enables.
module mem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic [31:0] fetch_data,
  output logic        fetch_valid,
  input  logic        load_req,
  input  logic [31:0] load_addr,
  output logic [31:0] load_data,
  output logic        load_valid,
  input  logic        store_req,
  input  logic [31:0] store_addr,
  input  logic [31:0] store_data,
`ifdef MEM_BYTE_STROBE_EN
  input  logic [3:0]  store_strb,
`endif
  output logic        store_done,
  output logic        stall,
  output logic        trap,
  output logic [31:0] trap_addr,
  output logic [1:0]  trap_cause
);

  localparam int         AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0] WAIT_INIT = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {CH_FETCH, CH_LOAD, CH_STORE} chan_t;

  function automatic logic [1:0] fault_cause(input logic [31:0] a);
    if (a[1:0] != 2'b00) return 2'b01;
    if ({2'b00, a[31:2]} >= 32'(MEM_WORDS)) return 2'b10;
    return 2'b00;
  endfunction

  logic [31:0] mem [MEM_WORDS];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  chan_t       chan_q, chan_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] fetch_data_q, fetch_data_d;
  logic [31:0] load_data_q, load_data_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        load_valid_q, load_valid_d;
  logic        store_done_q, store_done_d;
  logic        trap_q, trap_d;
  logic [31:0] trap_addr_q, trap_addr_d;
  logic [1:0]  trap_cause_q, trap_cause_d;

  logic        any_req;
  chan_t       sel_chan;
  logic [31:0] sel_addr;
  logic [3:0]  sel_strb;
  chan_t       cur_chan;
  logic [31:0] cur_addr;
  logic [1:0]  cur_cause;
  logic [31:0] mem_rd;
  logic        mem_we;

  // Arbitration; cur_* is the request that will occupy the next RESP cycle
  always_comb begin
    any_req  = fetch_req | load_req | store_req;
    sel_chan = CH_FETCH;
    sel_addr = fetch_addr;
    if (store_req) begin
      sel_chan = CH_STORE;
      sel_addr = store_addr;
    end else if (load_req) begin
      sel_chan = CH_LOAD;
      sel_addr = load_addr;
    end
`ifdef MEM_BYTE_STROBE_EN
    sel_strb = store_strb;
`else
    sel_strb = 4'hF;
`endif
    cur_chan  = (state_q == S_IDLE) ? sel_chan : chan_q;
    cur_addr  = (state_q == S_IDLE) ? sel_addr : addr_q;
    cur_cause = (state_q == S_IDLE) ? fault_cause(sel_addr) : cause_q;
  end

  assign mem_rd = mem[cur_addr[AW+1:2]];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    chan_d        = chan_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    strb_d        = strb_q;
    cause_d       = cause_q;
    fetch_data_d  = fetch_data_q;
    load_data_d   = load_data_q;
    fetch_valid_d = 1'b0;
    load_valid_d  = 1'b0;
    store_done_d  = 1'b0;
    trap_d        = 1'b0;
    trap_addr_d   = trap_addr_q;
    trap_cause_d  = trap_cause_q;

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          chan_d  = sel_chan;
          addr_d  = sel_addr;
          wdata_d = store_data;
          strb_d  = sel_strb;
          cause_d = fault_cause(sel_addr);
          cnt_d   = WAIT_INIT;
          state_d = (LATENCY <= 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Response outputs are loaded on the edge that enters RESP so they are
    // visible for exactly the RESP cycle.
    if (state_d == S_RESP) begin
      if (cur_cause != 2'b00) begin
        trap_d       = 1'b1;
        trap_addr_d  = cur_addr;
        trap_cause_d = cur_cause;
      end else begin
        unique case (cur_chan)
          CH_FETCH: begin
            fetch_valid_d = 1'b1;
            fetch_data_d  = mem_rd;
          end
          CH_LOAD: begin
            load_valid_d = 1'b1;
            load_data_d  = mem_rd;
          end
          CH_STORE: store_done_d = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      chan_q        <= CH_FETCH;
      addr_q        <= 32'h0;
      wdata_q       <= 32'h0;
      strb_q        <= 4'h0;
      cause_q       <= 2'b00;
      fetch_data_q  <= 32'h0;
      load_data_q   <= 32'h0;
      fetch_valid_q <= 1'b0;
      load_valid_q  <= 1'b0;
      store_done_q  <= 1'b0;
      trap_q        <= 1'b0;
      trap_addr_q   <= 32'h0;
      trap_cause_q  <= 2'b00;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      chan_q        <= chan_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      strb_q        <= strb_d;
      cause_q       <= cause_d;
      fetch_data_q  <= fetch_data_d;
      load_data_q   <= load_data_d;
      fetch_valid_q <= fetch_valid_d;
      load_valid_q  <= load_valid_d;
      store_done_q  <= store_done_d;
      trap_q        <= trap_d;
      trap_addr_q   <= trap_addr_d;
      trap_cause_q  <= trap_cause_d;
    end
  end

  // Backing store is never reset; a reset in the RESP cycle suppresses the write
  assign mem_we = (state_q == S_RESP) && (chan_q == CH_STORE) && (cause_q == 2'b00) && !reset;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (strb_q[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign stall = (fetch_req && !(state_q == S_RESP && chan_q == CH_FETCH)) ||
                 (load_req  && !(state_q == S_RESP && chan_q == CH_LOAD))  ||
                 (store_req && !(state_q == S_RESP && chan_q == CH_STORE));

  assign fetch_data  = fetch_data_q;
  assign fetch_valid = fetch_valid_q;
  assign load_data   = load_data_q;
  assign load_valid  = load_valid_q;
  assign store_done  = store_done_q;
  assign trap        = trap_q;
  assign trap_addr   = trap_addr_q;
  assign trap_cause  = trap_cause_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder
// Reference: word array plus response times derived from acceptance cycle and priority.
module tb_mem_responder;

  localparam int L       = 2;
  localparam int MW      = 1024;
  localparam int CH_F    = 0;
  localparam int CH_L    = 1;
  localparam int CH_S    = 2;
  localparam int CH_NONE = -1;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req, load_req, store_req;
  logic [31:0] fetch_addr, load_addr, store_addr, store_data;
  logic [3:0]  store_strb;
  logic [31:0] fetch_data, load_data, trap_addr;
  logic        fetch_valid, load_valid, store_done, stall, trap;
  logic [1:0]  trap_cause;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model [MW];
  logic [31:0] last_fetch, last_load, last_taddr;
  logic [1:0]  last_tcause;

  always #5 clk = ~clk;

  mem_responder #(.MEM_WORDS(MW), .LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_data(fetch_data), .fetch_valid(fetch_valid),
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data), .load_valid(load_valid),
    .store_req(store_req), .store_addr(store_addr), .store_data(store_data),
`ifdef MEM_BYTE_STROBE_EN
    .store_strb(store_strb),
`endif
    .store_done(store_done), .stall(stall), .trap(trap),
    .trap_addr(trap_addr), .trap_cause(trap_cause)
  );

  function automatic logic [1:0] exp_cause(input logic [31:0] a);
    if (a % 4 != 0) return 2'd1;
    if (a >= 4 * MW) return 2'd2;
    return 2'd0;
  endfunction

  // {fetch_valid, load_valid, store_done, trap}
  function automatic logic [3:0] exp_pulse(input int ch, input logic [31:0] a);
    if (exp_cause(a) != 2'd0) return 4'b0001;
    if (ch == CH_F) return 4'b1000;
    if (ch == CH_L) return 4'b0100;
    return 4'b0010;
  endfunction

  function automatic logic [3:0] eff_strb(input logic [3:0] s);
`ifdef MEM_BYTE_STROBE_EN
    return s;
`else
    return s | 4'hF;
`endif
  endfunction

  function automatic logic [31:0] rand_addr();
    int          r;
    logic [31:0] w;
    r = $urandom_range(0, 9);
    w = 32'($urandom_range(0, 15)) << 2;
    if (r == 0) return w | 32'($urandom_range(1, 3));
    if (r == 1) return 32'h1000 + (32'($urandom_range(0, 1023)) << 2);
    return w;
  endfunction

  task automatic drive(input int ch, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic on);
    case (ch)
      CH_F: begin fetch_req = on; fetch_addr = a; end
      CH_L: begin load_req = on; load_addr = a; end
      CH_S: begin store_req = on; store_addr = a; store_data = d; store_strb = s; end
      default: ;
    endcase
  endtask

  // Issues one request (or two simultaneous ones, ch_a having higher priority)
  // at the current cycle N and checks every cycle up to the last response.
  task automatic run_txn(input string tag,
                         input int ch_a, input logic [31:0] addr_a, input logic [31:0] data_a, input logic [3:0] strb_a,
                         input int ch_b, input logic [31:0] addr_b, input logic [31:0] data_b, input logic [3:0] strb_b,
                         input bit early);
    int          ch [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [3:0]  sb [2];
    bit          pending [2];
    int          last_k, ridx, idx;
    logic [3:0]  pulse, es;
    logic [1:0]  cause;
    logic [31:0] word;
    logic        exp_stall;
    ch[0] = ch_a; ad[0] = addr_a; wd[0] = data_a; sb[0] = strb_a;
    ch[1] = ch_b; ad[1] = addr_b; wd[1] = data_b; sb[1] = strb_b;
    pending[0] = 1'b1;
    pending[1] = (ch_b != CH_NONE);
    last_k = (ch_b == CH_NONE) ? L : 2 * L + 1;
    drive(ch_a, addr_a, data_a, strb_a, 1'b1);
    drive(ch_b, addr_b, data_b, strb_b, 1'b1);
    for (int k = 0; k <= last_k; k++) begin
      @(negedge clk);
      if (k == 0) begin
        total++;
        if ({fetch_data, load_data, trap_addr, trap_cause} !== {last_fetch, last_load, last_taddr, last_tcause}) begin
          bad++;
          $display("FAIL %s hold: got fd=%h ld=%h ta=%h tc=%0d exp fd=%h ld=%h ta=%h tc=%0d", tag,
                   fetch_data, load_data, trap_addr, trap_cause, last_fetch, last_load, last_taddr, last_tcause);
        end
      end
      ridx = (k == L) ? 0 : ((k == last_k && ch_b != CH_NONE) ? 1 : -1);
      if (ridx >= 0) begin
        cause = exp_cause(ad[ridx]);
        pulse = exp_pulse(ch[ridx], ad[ridx]);
        total++;
        if ({fetch_valid, load_valid, store_done, trap} !== pulse) begin
          bad++;
          $display("FAIL %s pulse@%0d: got %b exp %b", tag, k, {fetch_valid, load_valid, store_done, trap}, pulse);
        end
        if (cause != 2'd0) begin
          last_taddr  = ad[ridx];
          last_tcause = cause;
          total++;
          if ({trap_addr, trap_cause} !== {last_taddr, last_tcause}) begin
            bad++;
            $display("FAIL %s trap_info: got %h/%0d exp %h/%0d", tag, trap_addr, trap_cause, last_taddr, last_tcause);
          end
        end else if (ch[ridx] == CH_S) begin
          idx = int'(ad[ridx] >> 2);
          es  = eff_strb(sb[ridx]);
          for (int b = 0; b < 4; b++)
            if (es[b]) model[idx][8*b +: 8] = wd[ridx][8*b +: 8];
        end else begin
          word = model[int'(ad[ridx] >> 2)];
          if (ch[ridx] == CH_F) last_fetch = word;
          else                  last_load  = word;
          total++;
          if ((ch[ridx] == CH_F ? fetch_data : load_data) !== word) begin
            bad++;
            $display("FAIL %s rdata: got %h exp %h", tag, (ch[ridx] == CH_F ? fetch_data : load_data), word);
          end
        end
        pending[ridx] = 1'b0;
      end else begin
        total++;
        if ({fetch_valid, load_valid, store_done, trap} !== 4'b0000) begin
          bad++;
          $display("FAIL %s idle_pulse@%0d: got %b exp 0000", tag, k, {fetch_valid, load_valid, store_done, trap});
        end
      end
      exp_stall = (pending[0] && !(early && k >= 1)) || pending[1];
      total++;
      if (stall !== exp_stall) begin
        bad++;
        $display("FAIL %s stall@%0d: got %b exp %b", tag, k, stall, exp_stall);
      end
      if ((early && k == 0) || (ridx == 0 && ch_b != CH_NONE)) begin
        @(posedge clk); #1;
        drive(ch_a, addr_a, data_a, strb_a, 1'b0);
      end
    end
    @(posedge clk); #1;
    drive(ch_a, addr_a, data_a, strb_a, 1'b0);
    drive(ch_b, addr_b, data_b, strb_b, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fetch_req = 0; load_req = 0; store_req = 0;
    fetch_addr = 0; load_addr = 0; store_addr = 0; store_data = 0; store_strb = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({fetch_valid, load_valid, store_done, trap, stall} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_pulses: got %b exp 00000", {fetch_valid, load_valid, store_done, trap, stall});
    end
    total++;
    if ({fetch_data, load_data, trap_addr, trap_cause} !== 98'b0) begin
      bad++;
      $display("FAIL reset_regs: got fd=%h ld=%h ta=%h tc=%0d exp all zero", fetch_data, load_data, trap_addr, trap_cause);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    last_fetch = 0; last_load = 0; last_taddr = 0; last_tcause = 0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++)
      run_txn("fill", CH_S, 32'(i * 4), $urandom, 4'hF, CH_NONE, 0, 0, 0, 1'b0);
  endtask

  task automatic test_store_then_load();
    run_txn("st_ld", CH_S, 32'h10, 32'hDEADBEEF, 4'hF, CH_L, 32'h10, 0, 0, 1'b0);
    total++;
    if (load_data !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL st_ld_value: got %h exp deadbeef", load_data);
    end
  endtask

  task automatic test_dual_read();
    run_txn("ld_fe", CH_L, 32'h10, 0, 0, CH_F, 32'h0, 0, 0, 1'b0);
    run_txn("st_fe", CH_S, 32'h4, 32'h0BADF00D, 4'hF, CH_F, 32'h4, 0, 0, 1'b0);
  endtask

  task automatic test_faults();
    run_txn("mis_ld", CH_L, 32'h12, 0, 0, CH_NONE, 0, 0, 0, 1'b0);
    total++;
    if ({trap_addr, trap_cause} !== {32'h12, 2'b01}) begin
      bad++;
      $display("FAIL mis_ld_info: got %h/%0d exp 12/1", trap_addr, trap_cause);
    end
    run_txn("oor_ld", CH_L, 32'h1000, 0, 0, CH_NONE, 0, 0, 0, 1'b0);
    run_txn("both_fe", CH_F, 32'h1003, 0, 0, CH_NONE, 0, 0, 0, 1'b0);
    run_txn("mis_st", CH_S, 32'h11, 32'h12345678, 4'hF, CH_NONE, 0, 0, 0, 1'b0);
    run_txn("oor_st", CH_S, 32'h2010, 32'h87654321, 4'hF, CH_L, 32'h10, 0, 0, 1'b0);
    run_txn("last_ok", CH_L, 32'hFFC, 0, 0, CH_NONE, 0, 0, 0, 1'b0);
  endtask

  task automatic test_early_drop();
    run_txn("drop_st", CH_S, 32'h8, 32'hCAFEF00D, 4'hF, CH_NONE, 0, 0, 0, 1'b1);
    run_txn("drop_ld", CH_L, 32'h8, 0, 0, CH_NONE, 0, 0, 0, 1'b1);
  endtask

  task automatic test_reset_abort();
    drive(CH_S, 32'h20, 32'h55AA55AA, 4'hF, 1'b1);
    @(negedge clk);
    total++;
    if ({store_done, stall} !== 2'b01) begin
      bad++;
      $display("FAIL abort_accept: got done/stall=%b exp 01", {store_done, stall});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    drive(CH_S, 32'h20, 32'h55AA55AA, 4'hF, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    last_fetch = 0; last_load = 0; last_taddr = 0; last_tcause = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if ({fetch_valid, load_valid, store_done, trap} !== 4'b0000) begin
        bad++;
        $display("FAIL abort_pulse@%0d: got %b exp 0000", k, {fetch_valid, load_valid, store_done, trap});
      end
    end
    @(posedge clk); #1;
    run_txn("abort_ld", CH_L, 32'h20, 0, 0, CH_NONE, 0, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    int sel, pk;
    for (int it = 0; it < 60; it++) begin
      sel = $urandom_range(0, 4);
      if (sel < 3) begin
        run_txn("rnd1", sel, rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                CH_NONE, 0, 0, 0, ($urandom_range(0, 3) == 0));
      end else begin
        pk = $urandom_range(0, 2);
        run_txn("rnd2", (pk == 2) ? CH_L : CH_S, rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                (pk == 0) ? CH_L : CH_F, rand_addr(), 0, 0, 1'b0);
      end
    end
  endtask

`ifdef MEM_BYTE_STROBE_EN
  task automatic test_strobe();
    run_txn("strb_init", CH_S, 32'h20, 32'h11223344, 4'hF, CH_NONE, 0, 0, 0, 1'b0);
    run_txn("strb_wr", CH_S, 32'h20, 32'hAABBCCDD, 4'b0101, CH_L, 32'h20, 0, 0, 1'b0);
    total++;
    if (load_data !== 32'h11BB33DD) begin
      bad++;
      $display("FAIL strb_value: got %h exp 11bb33dd", load_data);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_store_then_load();
    test_dual_read();
    test_faults();
    test_early_drop();
    test_reset_abort();
`ifdef MEM_BYTE_STROBE_EN
    test_strobe();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
